ex_mem_skid_stage: RTL and testbench

Parametrised EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer. It carries a data payload and a control payload from the execute stage to the memory stage.
- Back-pressure: when the memory stage stalls, in-flight instructions are held and none are lost.
- Flush: the stage drops its contents, and the memory stage sees only bubble control values.
- It replaces the free-running EX/MEM latch. All CPU pipeline boundaries use it.

---
 rtl/ex_mem_skid_stage.sv | 94 +++++++++
 tb/tb_ex_mem_skid_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX/MEM pipeline register with valid/ready handshake and 2-entry skid buffer.
// Revision: 1.0
`default_nettype none

module ex_mem_skid_stage #(
  parameter int                 DATA_W      = 110,
  parameter int                 CTRL_W      = 10,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   main_data_q;
  logic [CTRL_W-1:0]   main_ctrl_q;
  logic [DATA_W-1:0]   skid_data_q;
  logic [CTRL_W-1:0]   skid_ctrl_q;

  logic                in_fire;
  logic                out_fire;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
  assign occupancy = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
    end else if (flush) begin
      // Payload registers keep stale values; out_ctrl is masked by out_valid.
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_q     <= ST_ONE;
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
          end else if (in_fire) begin
            state_q     <= ST_FULL;
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
          end else if (out_fire) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_q     <= ST_ONE;
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_skid_stage.sv
// tb_ex_mem_skid_stage: vector table, hand-written corner sequences and a queue-model random run.
`default_nettype none

module tb_ex_mem_skid_stage;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic         rst_n, flush, in_valid, out_ready;
  logic [109:0] in_data;
  logic [9:0]   in_ctrl;
  logic         in_ready, out_valid;
  logic [109:0] out_data;
  logic [9:0]   out_ctrl;
  logic [1:0]   occupancy;

  ex_mem_skid_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy)
  );

  // Narrow instance with a non-zero bubble value
  logic         p_rst_n, p_flush, p_iv, p_ordy, p_ir, p_ov;
  logic [7:0]   p_d, p_od;
  logic [2:0]   p_c, p_oc;
  logic [1:0]   p_occ;

  ex_mem_skid_stage #(.DATA_W(8), .CTRL_W(3), .CTRL_BUBBLE(3'b100)) dut_p (
    .clk(clk), .rst_n(p_rst_n), .in_valid(p_iv), .in_ready(p_ir),
    .in_data(p_d), .in_ctrl(p_c), .flush(p_flush), .out_valid(p_ov),
    .out_ready(p_ordy), .out_data(p_od), .out_ctrl(p_oc), .occupancy(p_occ)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         rst_n;
    logic         flush;
    logic         iv;
    logic [109:0] d;
    logic [9:0]   c;
    logic         ordy;
    logic         ev;
    logic         er;
    logic [1:0]   eocc;
    logic         chkd;
    logic [109:0] ed;
    logic [9:0]   ec;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic r, input logic f, input logic iv, input logic [109:0] d,
                      input logic [9:0] c, input logic ordy, input logic ev, input logic er,
                      input logic [1:0] eocc, input logic chkd, input logic [109:0] ed,
                      input logic [9:0] ec);
    vec_t v;
    v.rst_n = r; v.flush = f; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
    v.ev = ev; v.er = er; v.eocc = eocc; v.chkd = chkd; v.ed = ed; v.ec = ec;
    vecs.push_back(v);
  endtask

  typedef struct {
    logic [109:0] d;
    logic [9:0]   c;
  } ent_t;

  ent_t model_q[$];

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 128'(out_valid), 128'(model_q.size() != 0));
    chk({tag, "_ready"}, 128'(in_ready),  128'(model_q.size() < 2));
    chk({tag, "_occ"},   128'(occupancy), 128'(model_q.size()));
    chk({tag, "_ctrl"},  128'(out_ctrl),  128'((model_q.size() != 0) ? model_q[0].c : 10'h0));
    if (model_q.size() != 0) chk({tag, "_data"}, 128'(out_data), 128'(model_q[0].d));
  endtask

  initial begin
    logic [127:0] rnd;
    bit mi, mo;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    p_rst_n = 1'b0; p_flush = 1'b0; p_iv = 1'b0; p_ordy = 1'b0; p_d = '0; p_c = '0;

    //   rst f iv data     ctrl    ordy ev er occ chkd exp_data exp_ctrl
    addv(0, 0, 1, 110'h155, 10'h155, 0, 0, 1, 0, 1, 110'h0,  10'h0);   // reset hold
    addv(0, 0, 1, 110'h155, 10'h155, 0, 0, 1, 0, 1, 110'h0,  10'h0);
    addv(1, 0, 0, 110'h0,   10'h0,   1, 0, 1, 0, 1, 110'h0,  10'h0);   // nothing emitted
    addv(1, 0, 1, 110'hA1,  10'h011, 1, 1, 1, 1, 1, 110'hA1, 10'h011); // A accepted
    addv(1, 0, 1, 110'hB2,  10'h022, 0, 1, 0, 2, 1, 110'hA1, 10'h011); // B to skid
    addv(1, 0, 1, 110'hC3,  10'h033, 0, 1, 0, 2, 1, 110'hA1, 10'h011); // C held upstream
    addv(1, 0, 1, 110'hC3,  10'h033, 1, 1, 1, 1, 1, 110'hB2, 10'h022); // A out, skid->main
    addv(1, 0, 1, 110'hC3,  10'h033, 0, 1, 0, 2, 1, 110'hB2, 10'h022); // C into skid
    addv(1, 0, 0, 110'h0,   10'h0,   1, 1, 1, 1, 1, 110'hC3, 10'h033); // B out
    addv(1, 0, 0, 110'h0,   10'h0,   1, 0, 1, 0, 0, 110'h0,  10'h0);   // C out
    addv(1, 0, 1, 110'hD4,  10'h044, 0, 1, 1, 1, 1, 110'hD4, 10'h044);
    addv(1, 0, 1, 110'hE5,  10'h055, 0, 1, 0, 2, 1, 110'hD4, 10'h044);
    addv(1, 1, 1, 110'hF6,  10'h066, 0, 0, 1, 0, 0, 110'h0,  10'h0);   // flush in FULL
    addv(1, 0, 0, 110'h0,   10'h0,   1, 0, 1, 0, 0, 110'h0,  10'h0);   // flushed input gone
    addv(1, 0, 1, 110'h17,  10'h077, 0, 1, 1, 1, 1, 110'h17, 10'h077);
    addv(1, 0, 1, 110'h28,  10'h008, 0, 1, 0, 2, 1, 110'h17, 10'h077);
    addv(0, 1, 1, 110'h39,  10'h009, 1, 0, 1, 0, 1, 110'h0,  10'h0);   // reset beats flush/fire
    addv(1, 0, 0, 110'h0,   10'h0,   1, 0, 1, 0, 1, 110'h0,  10'h0);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; flush = vecs[i].flush; in_valid = vecs[i].iv;
      in_data = vecs[i].d; in_ctrl = vecs[i].c; out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(vecs[i].ev));
      chk($sformatf("vec%0d_ready", i), 128'(in_ready),  128'(vecs[i].er));
      chk($sformatf("vec%0d_occ", i),   128'(occupancy), 128'(vecs[i].eocc));
      chk($sformatf("vec%0d_ctrl", i),  128'(out_ctrl),  128'(vecs[i].ec));
      if (vecs[i].chkd) chk($sformatf("vec%0d_data", i), 128'(out_data), 128'(vecs[i].ed));
    end

    // Streaming with out_ready high: one entry per cycle, never more than one held
    rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 110'(i); in_ctrl = 10'(i);
      @(posedge clk); #1;
      chk($sformatf("stream%0d_data", i), 128'(out_data), 128'(i));
      chk($sformatf("stream%0d_ctrl", i), 128'(out_ctrl), 128'(i));
      chk($sformatf("stream%0d_occ", i),  128'(occupancy), 128'(1));
      chk($sformatf("stream%0d_ready", i), 128'(in_ready), 128'(1));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_drain_valid", 128'(out_valid), 128'(0));

    // Narrow instance: bubble value shown while idle, entry ctrl only while valid
    chk("p_reset_ctrl", 128'(p_oc), 128'(3'b100));
    chk("p_reset_data", 128'(p_od), 128'(0));
    p_rst_n = 1'b1; p_iv = 1'b1; p_d = 8'h5A; p_c = 3'b011; p_ordy = 1'b0;
    @(posedge clk); #1;
    chk("p_entry_valid", 128'(p_ov), 128'(1));
    chk("p_entry_ctrl",  128'(p_oc), 128'(3'b011));
    chk("p_entry_data",  128'(p_od), 128'(8'h5A));
    p_iv = 1'b0; p_ordy = 1'b1;
    @(posedge clk); #1;
    chk("p_idle_valid", 128'(p_ov), 128'(0));
    chk("p_idle_ctrl",  128'(p_oc), 128'(3'b100));

    // Random run against the queue model (DUT is empty here)
    model_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      rst_n     = ($urandom_range(0, 49) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = rnd[109:0];
      in_ctrl   = 10'($urandom());
      mi = in_valid && (model_q.size() < 2);
      mo = out_ready && (model_q.size() != 0);
      @(posedge clk); #1;
      if (!rst_n || flush) begin
        model_q.delete();
      end else begin
        ent_t e;
        if (mo) void'(model_q.pop_front());
        e.d = in_data; e.c = in_ctrl;
        if (mi) model_q.push_back(e);
      end
      check_model($sformatf("rnd%0d", cyc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
